wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 97 +++++++++
 tb/tb_wb_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// ============================================================================
// Module   : wb_stage
// Purpose  : Write-back stage register, 16x32 register file with
//            write-through read bypass, and a retired-instruction counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             in_valid,
  input  logic             needs_wb,
  input  logic             is_load,
  input  logic [3:0]       wb_addr_in,
  input  logic [31:0]      rdata,
  input  logic [31:0]      pdata,
  input  logic [3:0]       ra_addr,
  input  logic [3:0]       rb_addr,
  output logic [31:0]      ra_data,
  output logic [31:0]      rb_data,
  output logic             fwd_valid,
  output logic [3:0]       fwd_addr,
  output logic [31:0]      fwd_data,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_v;
  logic             r_wb;
  logic [3:0]       r_addr;
  logic [31:0]      r_data;
  logic [31:0]      r_rf [16];
  logic [CNT_W-1:0] r_cnt;

  logic             w_commit;
  logic             w_rf_we;

  assign w_commit = ~stall & r_v;
  assign w_rf_we  = w_commit & r_wb & (r_addr != 4'd0);

  // The instruction in the stage commits on the same edge the next one loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= 1'b0;
      r_wb   <= 1'b0;
      r_addr <= 4'd0;
      r_data <= 32'd0;
      r_cnt  <= '0;
      for (int i = 0; i < 16; i++) begin
        r_rf[i] <= 32'd0;
      end
    end else if (!stall) begin
      if (w_rf_we) begin
        r_rf[r_addr] <= r_data;
      end
      if (w_commit) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
      r_v    <= in_valid;
      r_wb   <= needs_wb;
      r_addr <= wb_addr_in;
      r_data <= is_load ? rdata : pdata;
    end
  end

  // Bypass ignores the r0 guard on purpose: index 0 is forced to zero first.
  always_comb begin
    ra_data = r_rf[ra_addr];
    if (ra_addr == 4'd0) begin
      ra_data = 32'd0;
    end else if (r_v && r_wb && (r_addr == ra_addr)) begin
      ra_data = r_data;
    end
  end

  always_comb begin
    rb_data = r_rf[rb_addr];
    if (rb_addr == 4'd0) begin
      rb_data = 32'd0;
    end else if (r_v && r_wb && (r_addr == rb_addr)) begin
      rb_data = r_data;
    end
  end

  assign fwd_valid   = r_v & r_wb & (r_addr != 4'd0);
  assign fwd_addr    = r_addr;
  assign fwd_data    = r_data;
  assign retired_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Directed self-checking bench for wb_stage (CNT_W = 4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_stage;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall;
  logic             in_valid;
  logic             needs_wb;
  logic             is_load;
  logic [3:0]       wb_addr_in;
  logic [31:0]      rdata;
  logic [31:0]      pdata;
  logic [3:0]       ra_addr;
  logic [3:0]       rb_addr;
  logic [31:0]      ra_data;
  logic [31:0]      rb_data;
  logic             fwd_valid;
  logic [3:0]       fwd_addr;
  logic [31:0]      fwd_data;
  logic [CNT_W-1:0] retired_cnt;

  int errors = 0;
  int checks = 0;

  wb_stage #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .in_valid    (in_valid),
    .needs_wb    (needs_wb),
    .is_load     (is_load),
    .wb_addr_in  (wb_addr_in),
    .rdata       (rdata),
    .pdata       (pdata),
    .ra_addr     (ra_addr),
    .rb_addr     (rb_addr),
    .ra_data     (ra_data),
    .rb_data     (rb_data),
    .fwd_valid   (fwd_valid),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wb, input logic ld,
                       input logic [3:0] a, input logic [31:0] rd, input logic [31:0] pd);
    in_valid   = v;
    needs_wb   = wb;
    is_load    = ld;
    wb_addr_in = a;
    rdata      = rd;
    pdata      = pd;
  endtask

  initial begin
    logic [CNT_W-1:0] exp_cnt;
    rst_n = 1'b0;
    stall = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    ra_addr = 4'd3;
    rb_addr = 4'd5;
    #3;
    chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
    chk("rst_cnt", {28'd0, retired_cnt}, 32'd0);
    chk("rst_ra", ra_data, 32'd0);
    #5 rst_n = 1'b1;

    // ALU write to r3 with bypass, then commit
    drive(1'b1, 1'b1, 1'b0, 4'd3, 32'hFFFF_FFFF, 32'h0000_00AA);
    tick();
    chk("alu_fwd_valid", {31'd0, fwd_valid}, 32'd1);
    chk("alu_fwd_addr", {28'd0, fwd_addr}, 32'd3);
    chk("alu_fwd_data", fwd_data, 32'h0000_00AA);
    chk("alu_bypass_ra", ra_data, 32'h0000_00AA);
    chk("alu_cnt_pre", {28'd0, retired_cnt}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 4'd3, 32'd0, 32'h0000_0011);
    tick();
    chk("alu_cnt_post", {28'd0, retired_cnt}, 32'd1);
    chk("alu_rf_ra", ra_data, 32'h0000_00AA);
    chk("bubble_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    tick();
    chk("bubble_no_count", {28'd0, retired_cnt}, 32'd1);
    chk("bubble_no_write", ra_data, 32'h0000_00AA);

    // Load select into r5
    drive(1'b1, 1'b1, 1'b1, 4'd5, 32'h1234_5678, 32'd0);
    tick();
    chk("ld_fwd_data", fwd_data, 32'h1234_5678);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    chk("ld_rf_rb", rb_data, 32'h1234_5678);
    chk("ld_cnt", {28'd0, retired_cnt}, 32'd2);

    // r0 guard
    ra_addr = 4'd0;
    drive(1'b1, 1'b1, 1'b0, 4'd0, 32'd0, 32'hDEAD_BEEF);
    #1;
    chk("r0_ra_before", ra_data, 32'd0);
    tick();
    chk("r0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("r0_fwd_data", fwd_data, 32'hDEAD_BEEF);
    chk("r0_ra_pending", ra_data, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    chk("r0_ra_after", ra_data, 32'd0);
    chk("r0_cnt", {28'd0, retired_cnt}, 32'd3);

    // Stall with pending write to r7
    rb_addr = 4'd7;
    drive(1'b1, 1'b1, 1'b0, 4'd7, 32'd0, 32'h0000_0055);
    tick();
    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 4'd7, 32'd0, 32'h0000_0099);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_cnt", {28'd0, retired_cnt}, 32'd3);
      chk("stall_bypass_rb", rb_data, 32'h0000_0055);
      chk("stall_fwd_data", fwd_data, 32'h0000_0055);
    end
    stall = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    chk("stall_rel_cnt", {28'd0, retired_cnt}, 32'd4);
    chk("stall_rel_rf", rb_data, 32'h0000_0055);
    tick();
    chk("stall_single_commit", {28'd0, retired_cnt}, 32'd4);

    // Bypass must beat a stale RF entry
    ra_addr = 4'd3;
    drive(1'b1, 1'b1, 1'b0, 4'd3, 32'd0, 32'h0000_0077);
    tick();
    chk("stale_bypass_ra", ra_data, 32'h0000_0077);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    chk("stale_cnt", {28'd0, retired_cnt}, 32'd5);

    // 16 back-to-back non-writing commits wrap the 4-bit counter
    exp_cnt = 4'd5;
    drive(1'b1, 1'b0, 1'b0, 4'd3, 32'd0, 32'hFFFF_0000);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k > 1) exp_cnt = exp_cnt + 4'd1;
      chk("wrap_cnt", {28'd0, retired_cnt}, {28'd0, exp_cnt});
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    chk("wrap_cnt_final", {28'd0, retired_cnt}, 32'd5);
    chk("wrap_no_wb_rf", ra_data, 32'h0000_0077);

    // Asynchronous reset between edges with a pending write
    rb_addr = 4'd9;
    drive(1'b1, 1'b1, 1'b0, 4'd9, 32'd0, 32'h0000_0123);
    tick();
    chk("pre_rst_fwd_valid", {31'd0, fwd_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ra", ra_data, 32'd0);
    chk("arst_rb", rb_data, 32'd0);
    chk("arst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("arst_fwd_addr", {28'd0, fwd_addr}, 32'd0);
    chk("arst_fwd_data", fwd_data, 32'd0);
    chk("arst_cnt", {28'd0, retired_cnt}, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_load", fwd_data, 32'h0000_0123);
    chk("post_rst_cnt0", {28'd0, retired_cnt}, 32'd0);
    chk("post_rst_rf_clear", ra_data, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    chk("post_rst_cnt1", {28'd0, retired_cnt}, 32'd1);
    chk("post_rst_rf9", rb_data, 32'h0000_0123);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
